// File: rtl/video_stream_checker.sv
// rtl/video_stream_checker.sv - AXI4-Stream video sink checking frame structure, summing frames and applying back-pressure
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   en                1 = accept the stream; 0 = hold tready low and return to IDLE
//   clr               one-cycle pulse clearing err_flags and err_cnt
//   bp_mask           back-pressure pattern, bit i stalls rotating slot i
//   s_axis_*          incoming video stream (tuser = start of frame, tlast = end of line)
//   frame_done        one-cycle pulse after a clean frame has been accepted
//   frame_cnt         clean frames completed (wrapping)
//   frame_sum         sum of all pixels of the last clean frame
//   locked            last frame was clean; dropped by any error
//   err_flags         sticky {eol_late, eol_early, sof_missing, sof_early}
//   err_cnt           saturating error event counter
module video_stream_checker #(
    parameter int DATAW    = 32,
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080,
    parameter int HW       = 12,
    parameter int VW       = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [7:0]       bp_mask,
    input  logic [DATAW-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tlast,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
    output logic [DATAW-1:0] frame_sum,
    output logic             locked,
    output logic [3:0]       err_flags,
    output logic [15:0]      err_cnt
);

    localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [HW-1:0]    x, x_nxt;
    logic [VW-1:0]    y, y_nxt;
    logic [DATAW-1:0] acc, acc_nxt;
    logic             ferr, ferr_nxt;
    logic [2:0]       slot;

    logic             done_nxt;
    logic [15:0]      cnt_nxt;
    logic [DATAW-1:0] sum_nxt;
    logic             locked_nxt;
    logic [3:0]       flags_nxt;
    logic [15:0]      errcnt_nxt;

    logic             beat;
    logic             take_pix;
    logic [HW-1:0]    px;
    logic [VW-1:0]    py;
    logic [DATAW-1:0] base_acc;
    logic             base_err;
    logic [DATAW-1:0] sum_beat;
    logic             line_end;
    logic [3:0]       new_err;
    logic [2:0]       n_err;
    logic [16:0]      err_sum;

    assign s_axis_tready = en & (state != IDLE) & ~bp_mask[slot];
    assign beat          = s_axis_tvalid & s_axis_tready;

    always_comb begin
        state_nxt  = state;
        x_nxt      = x;
        y_nxt      = y;
        acc_nxt    = acc;
        ferr_nxt   = ferr;
        done_nxt   = 1'b0;
        cnt_nxt    = frame_cnt;
        sum_nxt    = frame_sum;
        locked_nxt = locked;
        flags_nxt  = err_flags;
        errcnt_nxt = err_cnt;
        take_pix   = 1'b0;
        px         = x;
        py         = y;
        base_acc   = acc;
        base_err   = ferr;
        sum_beat   = '0;
        line_end   = 1'b0;
        new_err    = '0;
        n_err      = '0;
        err_sum    = '0;

        // A beat carrying tuser always restarts at pixel (0,0) of a fresh,
        // error-free frame; the error (if any) is charged to the aborted one.
        case (state)
            IDLE: begin
                if (en) state_nxt = SEEK;
            end
            SEEK: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (beat && s_axis_tuser) begin
                    take_pix  = 1'b1;
                    px        = '0;
                    py        = '0;
                    base_acc  = '0;
                    base_err  = 1'b0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (beat) begin
                    if (s_axis_tuser) begin
                        new_err[0] = (x != '0) || (y != '0);
                        take_pix   = 1'b1;
                        px         = '0;
                        py         = '0;
                        base_acc   = '0;
                        base_err   = 1'b0;
                    end else if ((x == '0) && (y == '0)) begin
                        // (0,0) in RUN means "waiting for the next frame's first beat"
                        new_err[1] = 1'b1;
                        state_nxt  = SEEK;
                    end else begin
                        take_pix = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (take_pix) begin
            sum_beat   = base_acc + s_axis_tdata;
            line_end   = s_axis_tlast || (px == H_LAST);
            new_err[2] = s_axis_tlast && (px != H_LAST);
            new_err[3] = (px == H_LAST) && !s_axis_tlast;
            acc_nxt    = sum_beat;
            ferr_nxt   = base_err | new_err[2] | new_err[3];
            if (line_end) begin
                x_nxt = '0;
                if (py == V_LAST) begin
                    // Frame ends here whether the last line was short or not
                    y_nxt = '0;
                    if (!ferr_nxt) begin
                        done_nxt   = 1'b1;
                        sum_nxt    = sum_beat;
                        cnt_nxt    = frame_cnt + 16'd1;
                        locked_nxt = 1'b1;
                    end
                end else begin
                    y_nxt = py + 1'b1;
                end
            end else begin
                x_nxt = px + 1'b1;
                y_nxt = py;
            end
        end

        n_err   = {2'b00, new_err[0]} + {2'b00, new_err[1]}
                + {2'b00, new_err[2]} + {2'b00, new_err[3]};
        err_sum = {1'b0, err_cnt} + {14'd0, n_err};
        if (clr) begin
            flags_nxt  = new_err;
            errcnt_nxt = {13'd0, n_err};
        end else begin
            flags_nxt  = err_flags | new_err;
            errcnt_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
        if (new_err != '0) locked_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            acc        <= '0;
            ferr       <= 1'b0;
            slot       <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            frame_sum  <= '0;
            locked     <= 1'b0;
            err_flags  <= '0;
            err_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            x          <= x_nxt;
            y          <= y_nxt;
            acc        <= acc_nxt;
            ferr       <= ferr_nxt;
            if (en) slot <= slot + 3'd1;
            frame_done <= done_nxt;
            frame_cnt  <= cnt_nxt;
            frame_sum  <= sum_nxt;
            locked     <= locked_nxt;
            err_flags  <= flags_nxt;
            err_cnt    <= errcnt_nxt;
        end
    end

endmodule

// File: tb/tb_video_stream_checker.sv
// tb/tb_video_stream_checker.sv - randomized self-checking bench for video_stream_checker
module tb_video_stream_checker;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic [7:0]    bp_mask = '0;
    logic [DW-1:0] tdata = '0;
    logic          tvalid = 1'b0;
    logic          tuser = 1'b0;
    logic          tlast = 1'b0;
    logic          tready;
    logic          frame_done;
    logic [15:0]   frame_cnt;
    logic [DW-1:0] frame_sum;
    logic          locked;
    logic [3:0]    err_flags;
    logic [15:0]   err_cnt;

    video_stream_checker #(
        .DATAW(DW), .H_ACTIVE(H), .V_ACTIVE(V), .HW(12), .VW(12)
    ) dut (
        .clk(clk), .rst(rst_n), .en(en), .clr(clr), .bp_mask(bp_mask),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .s_axis_tuser(tuser), .s_axis_tlast(tlast),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .frame_sum(frame_sum),
        .locked(locked), .err_flags(err_flags), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int done_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a frame is a linear pixel index 0..H*V-1; modes 0 idle, 1 hunting SOF, 2 in stream
    int            m_mode = 0;
    int            m_pix = 0;
    int            m_slot = 0;
    logic [DW-1:0] m_acc = '0;
    bit            m_bad = 0;
    bit            e_done = 0;
    logic [15:0]   e_cnt = '0;
    logic [DW-1:0] e_sum = '0;
    bit            e_locked = 0;
    logic [3:0]    e_flags = '0;
    int            e_errcnt = 0;
    bit            m_take, m_pixel;
    logic [3:0]    m_ne;
    int            m_col, m_row, m_n;

    function automatic bit m_ready();
        return en && (m_mode != 0) && !bp_mask[m_slot];
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = 0; m_pix = 0; m_slot = 0; m_acc = '0; m_bad = 0;
            e_done = 0; e_cnt = '0; e_sum = '0; e_locked = 0; e_flags = '0; e_errcnt = 0;
        end else begin
            m_take  = m_ready() && tvalid;
            m_ne    = '0;
            m_pixel = 0;
            e_done  = 0;
            if (!en) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_take) begin
                if (m_mode == 1) begin
                    if (tuser) begin
                        m_pixel = 1; m_pix = 0; m_acc = '0; m_bad = 0; m_mode = 2;
                    end
                end else if (tuser) begin
                    m_ne[0] = (m_pix != 0);
                    m_pixel = 1; m_pix = 0; m_acc = '0; m_bad = 0;
                end else if (m_pix == 0) begin
                    m_ne[1] = 1'b1;
                    m_mode  = 1;
                end else begin
                    m_pixel = 1;
                end
                if (m_pixel) begin
                    m_col = m_pix % H;
                    m_row = m_pix / H;
                    m_acc = m_acc + tdata;
                    m_ne[2] = tlast && (m_col != H - 1);
                    m_ne[3] = !tlast && (m_col == H - 1);
                    if (m_ne[2] || m_ne[3]) m_bad = 1;
                    if (tlast || m_col == H - 1) begin
                        if (m_row == V - 1) begin
                            if (!m_bad) begin
                                e_done = 1; e_sum = m_acc; e_cnt = e_cnt + 16'd1; e_locked = 1;
                            end
                            m_pix = 0;
                        end else begin
                            m_pix = (m_row + 1) * H;
                        end
                    end else begin
                        m_pix = m_pix + 1;
                    end
                end
            end
            if (en) m_slot = (m_slot + 1) % 8;
            m_n = int'(m_ne[0]) + int'(m_ne[1]) + int'(m_ne[2]) + int'(m_ne[3]);
            if (clr) begin
                e_flags  = m_ne;
                e_errcnt = m_n;
            end else begin
                e_flags  = e_flags | m_ne;
                e_errcnt = (e_errcnt + m_n > 65535) ? 65535 : e_errcnt + m_n;
            end
            if (m_n != 0) e_locked = 0;
        end
        #1;
        chk("frame_done", 32'(frame_done), 32'(e_done));
        chk("frame_cnt", 32'(frame_cnt), 32'(e_cnt));
        chk("frame_sum", frame_sum, e_sum);
        chk("locked", 32'(locked), 32'(e_locked));
        chk("err_flags", 32'(err_flags), 32'(e_flags));
        chk("err_cnt", 32'(err_cnt), e_errcnt);
        if (frame_done === 1'b1) done_seen++;
    end

    initial forever begin
        @(negedge clk);
        #1;
        chk("tready", 32'(tready), 32'(m_ready()));
    end

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    beat_t q[$];
    beat_t b;
    bit    pend;

    task automatic push_frame(input logic [DW-1:0] start);
        for (int i = 0; i < H * V; i++)
            q.push_back('{d: start + DW'(i), u: (i == 0), l: ((i % H) == H - 1)});
    endtask

    // Streams the queue; stops early after n_acc accepted beats when n_acc > 0
    task automatic run_q(input int n_acc, input bit gaps);
        int got = 0;
        int cyc = 0;
        int lim = 8 * q.size() + 200;
        pend = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                q.delete(0);
                got++;
                pend = 0;
            end
            if (q.size() == 0 || (n_acc > 0 && got >= n_acc) || cyc >= lim) break;
            cyc++;
            clr = gaps && ($urandom_range(15) == 0);
            if (!gaps || $urandom_range(3) != 0) begin
                b = q[0];
                tvalid = 1'b1; tdata = b.d; tuser = b.u; tlast = b.l;
            end else begin
                tvalid = 1'b0; tdata = $urandom; tuser = 1'($urandom); tlast = 1'($urandom);
            end
            #1 pend = tvalid && tready;
        end
        tvalid = 1'b0;
        clr = 1'b0;
        chk("stream_timeout", 32'(cyc >= lim), 32'd0);
        if (cyc >= lim) q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int kind, idx;

    initial begin
        // 1: two clean frames
        idle(3);
        rst_n = 1'b1;
        en = 1'b1;
        done_seen = 0;
        push_frame(32'd1);
        push_frame(32'd1);
        run_q(0, 0);
        idle(3);
        chk("t1_done_pulses", done_seen, 2);
        chk("t1_frame_cnt", 32'(frame_cnt), 2);
        chk("t1_frame_sum", frame_sum, 36);
        chk("t1_locked", 32'(locked), 1);
        chk("t1_err_cnt", 32'(err_cnt), 0);

        // 2: alternating back-pressure
        bp_mask = 8'b1010_1010;
        push_frame(32'd1);
        run_q(0, 0);
        idle(3);
        chk("t2_frame_cnt", 32'(frame_cnt), 3);
        chk("t2_frame_sum", frame_sum, 36);
        bp_mask = '0;

        // 3: short line 0 (tlast on pixel 2)
        done_seen = 0;
        q.push_back('{d: 32'd1, u: 1'b1, l: 1'b0});
        q.push_back('{d: 32'd2, u: 1'b0, l: 1'b0});
        q.push_back('{d: 32'd3, u: 1'b0, l: 1'b1});
        for (int i = 0; i < H; i++)
            q.push_back('{d: 32'(5 + i), u: 1'b0, l: (i == H - 1)});
        run_q(0, 0);
        idle(3);
        chk("t3_err_flags", 32'(err_flags), 32'h4);
        chk("t3_err_cnt", 32'(err_cnt), 1);
        chk("t3_locked", 32'(locked), 0);
        chk("t3_done_pulses", done_seen, 0);

        // 4: missing SOF, then a clean frame
        pulse_clr();
        push_frame(32'd1);
        b = q[0]; b.u = 1'b0; q[0] = b;
        push_frame(32'd1);
        run_q(0, 0);
        idle(3);
        chk("t4_err_flags", 32'(err_flags), 32'h2);
        chk("t4_err_cnt", 32'(err_cnt), 1);
        chk("t4_frame_cnt", 32'(frame_cnt), 4);
        chk("t4_locked", 32'(locked), 1);

        // 5: en dropped mid-frame
        push_frame(32'd1);
        run_q(5, 0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t5_tready_en_low", 32'(tready), 0);
            @(negedge clk);
        end
        en = 1'b1;
        push_frame(32'd1);
        run_q(0, 0);
        idle(3);
        chk("t5_frame_cnt", 32'(frame_cnt), 5);
        chk("t5_frame_sum", frame_sum, 36);
        chk("t5_err_cnt", 32'(err_cnt), 1);

        // Randomized frames with injected faults, back-pressure, en drops and clr
        for (int it = 0; it < 60; it++) begin
            bp_mask = ($urandom_range(1) != 0) ? 8'($urandom) : 8'h00;
            push_frame($urandom);
            kind = $urandom_range(5);
            idx  = q.size() - H * V + $urandom_range(H * V - 1);
            if (kind == 1) begin
                b = q[idx]; b.u = ~b.u; q[idx] = b;
            end else if (kind == 2) begin
                b = q[idx]; b.l = ~b.l; q[idx] = b;
            end else if (kind == 3) begin
                q.delete(idx);
            end else if (kind == 4) begin
                run_q($urandom_range(1, 6), 1);
                en = 1'b0;
                idle($urandom_range(1, 4));
                en = 1'b1;
            end
            run_q(0, 1);
        end
        bp_mask = '0;
        idle(4);

        // 6: async reset mid-line, then error counter saturation
        push_frame(32'd1);
        run_q(2, 0);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_frame_done", 32'(frame_done), 0);
        chk("t6_rst_frame_cnt", 32'(frame_cnt), 0);
        chk("t6_rst_frame_sum", frame_sum, 0);
        chk("t6_rst_locked", 32'(locked), 0);
        chk("t6_rst_err_flags", 32'(err_flags), 0);
        chk("t6_rst_err_cnt", 32'(err_cnt), 0);
        chk("t6_rst_tready", 32'(tready), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 33000; i++)
            q.push_back('{d: $urandom, u: 1'b1, l: 1'b1});
        run_q(0, 0);
        idle(3);
        chk("t6_err_cnt_sat", 32'(err_cnt), 32'hFFFF);
        chk("t6_err_flags", 32'(err_flags), 32'h5);
        chk("t6_locked", 32'(locked), 0);
        chk("t6_frame_cnt", 32'(frame_cnt), 0);
        pulse_clr();
        idle(2);
        chk("t6_clr_err_cnt", 32'(err_cnt), 0);
        chk("t6_clr_err_flags", 32'(err_flags), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
